// File: rtl/l_buffer_multiload_pkg.sv
// Shared definitions for the lookup engines and the preprocess loader.
// Widths here describe the default build; modules take their own parameters.
package l_buffer_multiload_pkg;

    localparam int NUM_ENGINE  = 4;
    localparam int LIT_IDX_MAX = 8;
    localparam int CLA_W       = 64;
    localparam int PTR_ENTRY_W = 16;
    localparam int PTR_DEPTH   = 2 * LIT_IDX_MAX;

    typedef logic [CLA_W-1:0]                   node_t;
    typedef logic [PTR_ENTRY_W-1:0]             dummy_entry_t;
    typedef logic [PTR_DEPTH*PTR_ENTRY_W-1:0]   dummy_ptr_t;

endpackage

// File: rtl/l_buffer_ptr_assembler.sv
// Collects pointer entries into a full table and flags the cycle the last
// entry is written.
module l_buffer_ptr_assembler #(
    parameter int  LIT_IDX_MAX = l_buffer_multiload_pkg::LIT_IDX_MAX,
    parameter int  PTR_ENTRY_W = l_buffer_multiload_pkg::PTR_ENTRY_W,
    localparam int PTR_DEPTH   = 2 * LIT_IDX_MAX,
    localparam int CNT_W       = (PTR_DEPTH <= 2) ? 1 : $clog2(PTR_DEPTH)
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             load,
    input  logic [PTR_ENTRY_W-1:0]           entry,
    output logic [CNT_W-1:0]                 count,
    output logic [PTR_DEPTH*PTR_ENTRY_W-1:0] table_out,
    output logic                             done
);
    import l_buffer_multiload_pkg::*;

    logic [CNT_W-1:0]                 count_reg;
    logic [CNT_W-1:0]                 count_next;
    logic [PTR_DEPTH*PTR_ENTRY_W-1:0] table_reg;
    logic                             last_entry;

    assign last_entry = (count_reg == CNT_W'(PTR_DEPTH - 1));
    assign done       = load && last_entry;

    always_comb begin
        count_next = count_reg;
        if (load) begin
            count_next = last_entry ? '0 : count_reg + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_reg <= '0;
            table_reg <= '0;
        end else begin
            count_reg <= count_next;
            for (int i = 0; i < PTR_DEPTH; i++) begin
                if (load && count_reg == CNT_W'(i)) begin
                    table_reg[i*PTR_ENTRY_W +: PTR_ENTRY_W] <= entry;
                end
            end
        end
    end

    assign count     = count_reg;
    assign table_out = table_reg;

endmodule

// File: rtl/l_buffer_multiload.sv
// Preprocess loader: routes clauses to the selected engine and hands complete
// pointer tables to engines round-robin or by broadcast, with backpressure.
module l_buffer_multiload #(
    parameter int  NUM_ENGINE  = l_buffer_multiload_pkg::NUM_ENGINE,
    parameter int  LIT_IDX_MAX = l_buffer_multiload_pkg::LIT_IDX_MAX,
    parameter int  CLA_W       = l_buffer_multiload_pkg::CLA_W,
    parameter int  PTR_ENTRY_W = l_buffer_multiload_pkg::PTR_ENTRY_W,
    localparam int PTR_DEPTH   = 2 * LIT_IDX_MAX,
    localparam int ENG_W       = (NUM_ENGINE <= 2) ? 1 : $clog2(NUM_ENGINE),
    localparam int CNT_W       = (PTR_DEPTH <= 2) ? 1 : $clog2(PTR_DEPTH)
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [CLA_W-1:0]                 clause_in,
    input  logic                             load_clause_in,
    input  logic [PTR_ENTRY_W-1:0]           ptr_in,
    input  logic                             load_ptr_in,
    input  logic                             load_change_engine_in,
    input  logic                             ptr_broadcast_in,
    input  logic [NUM_ENGINE-1:0]            clause_ready_in,
    input  logic [NUM_ENGINE-1:0]            ptr_ready_in,
    output logic                             in_ready_out,
    output logic [CLA_W-1:0]                 clause_out,
    output logic [NUM_ENGINE-1:0]            clause_valid_out,
    output logic [PTR_DEPTH*PTR_ENTRY_W-1:0] ptr_out,
    output logic [NUM_ENGINE-1:0]            ptr_valid_out,
    output logic [CNT_W-1:0]                 ptr_count_out,
    output logic                             load_drop_err_out
);
    import l_buffer_multiload_pkg::*;

    logic [ENG_W-1:0]      engine_idx_reg;
    logic [ENG_W-1:0]      engine_idx_next;
    logic [ENG_W-1:0]      ptr_engine_idx_reg;
    logic [ENG_W-1:0]      ptr_engine_idx_wrap;
    logic [CLA_W-1:0]      clause_reg;
    logic [NUM_ENGINE-1:0] clause_pend_reg;
    logic [NUM_ENGINE-1:0] ptr_pend_reg;
    logic                  drop_err_reg;
    logic [NUM_ENGINE-1:0] clause_sel;
    logic [NUM_ENGINE-1:0] ptr_sel;
    logic                  in_ready;
    logic                  clause_accept;
    logic                  ptr_accept;
    logic                  table_done;

    // Ready depends only on held state, so no ready input can reach it combinationally.
    assign in_ready      = !(|clause_pend_reg) && !(|ptr_pend_reg);
    assign clause_accept = load_clause_in && in_ready;
    assign ptr_accept    = load_ptr_in && in_ready;

    always_comb begin
        engine_idx_next = engine_idx_reg;
        if (load_change_engine_in) begin
            engine_idx_next = (engine_idx_reg == ENG_W'(NUM_ENGINE - 1)) ? '0
                                                                        : engine_idx_reg + 1'b1;
        end
        ptr_engine_idx_wrap = (ptr_engine_idx_reg == ENG_W'(NUM_ENGINE - 1)) ? '0
                                                                            : ptr_engine_idx_reg + 1'b1;
    end

    // A clause accepted alongside an engine change targets the new engine.
    for (genvar gi = 0; gi < NUM_ENGINE; gi++) begin : g_sel
        assign clause_sel[gi] = (engine_idx_next == ENG_W'(gi));
        assign ptr_sel[gi]    = (ptr_engine_idx_reg == ENG_W'(gi));
    end

    l_buffer_ptr_assembler #(
        .LIT_IDX_MAX (LIT_IDX_MAX),
        .PTR_ENTRY_W (PTR_ENTRY_W)
    ) u_assembler (
        .clock     (clock),
        .reset     (reset),
        .load      (ptr_accept),
        .entry     (ptr_in),
        .count     (ptr_count_out),
        .table_out (ptr_out),
        .done      (table_done)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            engine_idx_reg     <= '0;
            ptr_engine_idx_reg <= '0;
            clause_reg         <= '0;
            clause_pend_reg    <= '0;
            ptr_pend_reg       <= '0;
            drop_err_reg       <= 1'b0;
        end else begin
            engine_idx_reg <= engine_idx_next;

            if (clause_accept) begin
                clause_reg      <= clause_in;
                clause_pend_reg <= clause_sel;
            end else begin
                clause_pend_reg <= clause_pend_reg & ~clause_ready_in;
            end

            if (table_done) begin
                if (ptr_broadcast_in) begin
                    ptr_pend_reg <= '1;
                end else begin
                    ptr_pend_reg       <= ptr_sel;
                    ptr_engine_idx_reg <= ptr_engine_idx_wrap;
                end
            end else begin
                ptr_pend_reg <= ptr_pend_reg & ~ptr_ready_in;
            end

            if ((load_clause_in || load_ptr_in) && !in_ready) begin
                drop_err_reg <= 1'b1;
            end
        end
    end

    assign in_ready_out      = in_ready;
    assign clause_out        = clause_reg;
    assign clause_valid_out  = clause_pend_reg;
    assign ptr_valid_out     = ptr_pend_reg;
    assign load_drop_err_out = drop_err_reg;

endmodule

// File: tb/tb_l_buffer_multiload.sv
// Directed bench for the loader: a 4-engine instance plus a 3-engine instance
// for the non-power-of-2 wrap.
module tb_l_buffer_multiload;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic          reset;
    logic [63:0]   clause_in;
    logic          load_clause_in;
    logic [15:0]   ptr_in;
    logic          load_ptr_in;
    logic          load_change_engine_in;
    logic          ptr_broadcast_in;
    logic [3:0]    clause_ready4, ptr_ready4;
    logic [2:0]    clause_ready3, ptr_ready3;

    logic          in_ready4, in_ready3;
    logic [63:0]   clause_out4, clause_out3;
    logic [3:0]    clause_valid4, ptr_valid4;
    logic [2:0]    clause_valid3, ptr_valid3;
    logic [255:0]  ptr_out4, ptr_out3;
    logic [3:0]    ptr_count4, ptr_count3;
    logic          err4, err3;

    int n_vec = 0;
    int n_bad = 0;

    l_buffer_multiload dut4 (
        .clock                 (clock),
        .reset                 (reset),
        .clause_in             (clause_in),
        .load_clause_in        (load_clause_in),
        .ptr_in                (ptr_in),
        .load_ptr_in           (load_ptr_in),
        .load_change_engine_in (load_change_engine_in),
        .ptr_broadcast_in      (ptr_broadcast_in),
        .clause_ready_in       (clause_ready4),
        .ptr_ready_in          (ptr_ready4),
        .in_ready_out          (in_ready4),
        .clause_out            (clause_out4),
        .clause_valid_out      (clause_valid4),
        .ptr_out               (ptr_out4),
        .ptr_valid_out         (ptr_valid4),
        .ptr_count_out         (ptr_count4),
        .load_drop_err_out     (err4)
    );

    l_buffer_multiload #(.NUM_ENGINE(3)) dut3 (
        .clock                 (clock),
        .reset                 (reset),
        .clause_in             (clause_in),
        .load_clause_in        (load_clause_in),
        .ptr_in                (ptr_in),
        .load_ptr_in           (load_ptr_in),
        .load_change_engine_in (load_change_engine_in),
        .ptr_broadcast_in      (ptr_broadcast_in),
        .clause_ready_in       (clause_ready3),
        .ptr_ready_in          (ptr_ready3),
        .in_ready_out          (in_ready3),
        .clause_out            (clause_out3),
        .clause_valid_out      (clause_valid3),
        .ptr_out               (ptr_out3),
        .ptr_valid_out         (ptr_valid3),
        .ptr_count_out         (ptr_count3),
        .load_drop_err_out     (err3)
    );

    task automatic chk_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic put_ptr(input logic [15:0] val, input logic bc);
        ptr_in           = val;
        load_ptr_in      = 1'b1;
        ptr_broadcast_in = bc;
        tick();
        load_ptr_in      = 1'b0;
        ptr_broadcast_in = 1'b0;
    endtask

    task automatic put_clause(input logic [63:0] val, input logic chg);
        clause_in             = val;
        load_clause_in        = 1'b1;
        load_change_engine_in = chg;
        tick();
        load_clause_in        = 1'b0;
        load_change_engine_in = 1'b0;
    endtask

    function automatic logic [15:0] entry4(input int i);
        return ptr_out4[i*16 +: 16];
    endfunction

    initial begin
        reset = 1'b1;
        clause_in = '0;
        load_clause_in = 1'b0;
        ptr_in = '0;
        load_ptr_in = 1'b0;
        load_change_engine_in = 1'b0;
        ptr_broadcast_in = 1'b0;
        clause_ready4 = 4'hF;
        ptr_ready4    = 4'hF;
        clause_ready3 = 3'h7;
        ptr_ready3    = 3'h7;

        // Reset state and a single clause with all engines ready
        do_reset();
        chk_vec("rst_in_ready", in_ready4, 1);
        chk_vec("rst_clause_valid", clause_valid4, 0);
        chk_vec("rst_ptr_valid", ptr_valid4, 0);
        chk_vec("rst_count", ptr_count4, 0);
        chk_vec("rst_err", err4, 0);
        chk_vec("rst_clause_out", clause_out4, 0);
        put_clause(64'hA5, 1'b0);
        chk_vec("cl_valid_t1", clause_valid4, 4'b0001);
        chk_vec("cl_data_t1", clause_out4, 64'hA5);
        chk_vec("cl_in_ready_t1", in_ready4, 0);
        tick();
        chk_vec("cl_valid_t2", clause_valid4, 0);
        chk_vec("cl_in_ready_t2", in_ready4, 1);

        // Engine index wrap: five changes then a clause
        do_reset();
        for (int i = 0; i < 5; i++) begin
            load_change_engine_in = 1'b1;
            tick();
        end
        load_change_engine_in = 1'b0;
        put_clause(64'h11, 1'b0);
        chk_vec("wrap3_valid", clause_valid3, 3'b100);
        chk_vec("wrap4_valid", clause_valid4, 4'b0010);
        tick();
        put_clause(64'h12, 1'b1);
        chk_vec("wrap3_chg_valid", clause_valid3, 3'b001);
        chk_vec("wrap4_chg_valid", clause_valid4, 4'b0100);
        tick();
        do_reset();
        put_clause(64'h22, 1'b1);
        chk_vec("same_cyc_chg4", clause_valid4, 4'b0010);
        chk_vec("same_cyc_chg3", clause_valid3, 3'b010);
        tick();

        // First table, ready held low for three cycles
        do_reset();
        ptr_ready4 = 4'h0;
        for (int i = 1; i <= 15; i++) put_ptr(16'(i), 1'b0);
        chk_vec("tbl0_count15", ptr_count4, 15);
        chk_vec("tbl0_no_valid", ptr_valid4, 0);
        put_ptr(16'd16, 1'b0);
        chk_vec("tbl0_valid", ptr_valid4, 4'b0001);
        chk_vec("tbl0_count0", ptr_count4, 0);
        chk_vec("tbl0_e0", entry4(0), 16'd1);
        chk_vec("tbl0_e15", entry4(15), 16'd16);
        chk_vec("tbl0_in_ready", in_ready4, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_vec("tbl0_hold_valid", ptr_valid4, 4'b0001);
            chk_vec("tbl0_hold_ready", in_ready4, 0);
        end
        ptr_ready4 = 4'h1;
        tick();
        chk_vec("tbl0_released", ptr_valid4, 0);
        chk_vec("tbl0_in_ready_back", in_ready4, 1);

        // Second table goes to engine 1
        ptr_ready4 = 4'h0;
        for (int i = 0; i < 16; i++) put_ptr(16'h100 + 16'(i), 1'b0);
        chk_vec("tbl1_valid", ptr_valid4, 4'b0010);
        chk_vec("tbl1_e7", entry4(7), 16'h107);
        ptr_ready4 = 4'hF;
        tick();

        // Broadcast table, engines released in order 3,0,2,1
        ptr_ready4 = 4'h0;
        for (int i = 0; i < 15; i++) put_ptr(16'h300 + 16'(i), 1'b0);
        put_ptr(16'h30F, 1'b1);
        chk_vec("bc_valid", ptr_valid4, 4'b1111);
        chk_vec("bc_e15", entry4(15), 16'h30F);
        ptr_ready4 = 4'b1000; tick();
        chk_vec("bc_after3", ptr_valid4, 4'b0111);
        chk_vec("bc_rdy_after3", in_ready4, 0);
        ptr_ready4 = 4'b0001; tick();
        chk_vec("bc_after0", ptr_valid4, 4'b0110);
        ptr_ready4 = 4'b0100; tick();
        chk_vec("bc_after2", ptr_valid4, 4'b0010);
        chk_vec("bc_rdy_after2", in_ready4, 0);
        ptr_ready4 = 4'b0010; tick();
        chk_vec("bc_after1", ptr_valid4, 4'b0000);
        chk_vec("bc_rdy_after1", in_ready4, 1);

        // Broadcast leaves the round-robin index alone: next table to engine 2
        ptr_ready4 = 4'h0;
        for (int i = 0; i < 16; i++) put_ptr(16'h400 + 16'(i), 1'b0);
        chk_vec("tbl3_valid", ptr_valid4, 4'b0100);
        ptr_ready4 = 4'hF;
        tick();

        // Strobes while a clause is pending are dropped and flagged
        clause_ready4 = 4'h0;
        put_clause(64'h5A, 1'b0);
        chk_vec("drop_pend_valid", clause_valid4, 4'b0001);
        chk_vec("drop_err_before", err4, 0);
        clause_in = 64'hFF;
        load_clause_in = 1'b1;
        ptr_in = 16'h77;
        load_ptr_in = 1'b1;
        tick();
        load_clause_in = 1'b0;
        load_ptr_in = 1'b0;
        chk_vec("drop_err", err4, 1);
        chk_vec("drop_count", ptr_count4, 0);
        chk_vec("drop_clause_out", clause_out4, 64'h5A);
        chk_vec("drop_valid_kept", clause_valid4, 4'b0001);
        clause_ready4 = 4'hF;
        tick();
        chk_vec("drop_released", clause_valid4, 0);
        chk_vec("drop_err_sticky", err4, 1);
        tick();
        chk_vec("drop_err_sticky2", err4, 1);

        // Reset part way through a table
        for (int i = 0; i < 7; i++) put_ptr(16'h500 + 16'(i), 1'b0);
        chk_vec("mid_count7", ptr_count4, 7);
        do_reset();
        chk_vec("mid_count_rst", ptr_count4, 0);
        chk_vec("mid_err_rst", err4, 0);
        ptr_ready4 = 4'h0;
        for (int i = 0; i < 16; i++) put_ptr(16'h200 + 16'(i), 1'b0);
        chk_vec("clean_valid", ptr_valid4, 4'b0001);
        chk_vec("clean_e0", entry4(0), 16'h200);
        chk_vec("clean_e6", entry4(6), 16'h206);
        chk_vec("clean_e15", entry4(15), 16'h20F);
        ptr_ready4 = 4'hF;
        tick();
        chk_vec("clean_released", ptr_valid4, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
